fix_msg_framer: RTL and testbench
=================================

Name: fix_msg_framer

Overview:
- Upstream stage of cam_cntrl.
- Consumes the raw FIX byte stream and locates message boundaries: a message starts at "8=" at a field start and ends at the SOH closing the "10=" checksum field.
- Packs message bytes into DATA_WIDTH words and drives cam_cntrl's write/start/end inputs.
- Bytes outside a message are discarded. Backpressure comes from cam_cntrl's full indication.

Parameters:
- DATA_WIDTH, 32: output word width; must be a multiple of 8. BPW = DATA_WIDTH/8.
- MAX_MSG_WORDS, 32: maximum words per message before a forced termination.
- SOH, 8'h01: FIX field delimiter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- byte_i  input  8  incoming stream byte.
- byte_valid_i  input  1  byte_i is valid this cycle.
- byte_ready_o  output  1  block accepts a byte this cycle.
- full_i  input  1  downstream CAM full (from cam_cntrl full_o).
- wr_cs_o  output  1  write chip select to cam_cntrl.
- wr_en_o  output  1  write enable to cam_cntrl.
- data_o  output  DATA_WIDTH  packed message word.
- start_message_o  output  1  pulse marking the first word of a message.
- end_message_o  output  1  pulse marking the last word of a message.
- msg_err_o  output  1  pulse on a malformed or overlong message.

Behaviour:
- Reset values: every output 0; byte_ready_o becomes 1 on the first cycle after reset deasserts (if full_i=0). FSM goes to IDLE, the partial word and counters clear.
- Reset mid-message discards the partial word. No end_message_o is issued.
- Byte accept = byte_valid_i && byte_ready_o. byte_ready_o = !full_i && state!=FLUSH.
- Packing is little-endian: the first byte of a word goes to data_o[7:0]. A word is written when BPW bytes have accumulated, or at end of message, where unused high bytes are zero.
- Write timing: registered. wr_cs_o=wr_en_o=1 for exactly one cycle, the cycle after the completing byte is accepted.
- start_message_o is coincident with the first word's write. end_message_o is coincident with the last word's write.
- A legal message is at least 9 bytes, so start and end never coincide when BPW<=4.
- FSM states:
  - IDLE: waiting for a message. On '8' (0x38): load byte 0, go to HDR. All other bytes are dropped.
  - HDR: on '=': append, go to BODY. On '8': restart the word with the new '8', stay in HDR. On any other byte: clear the word, go to IDLE.
  - BODY: append each byte and track a field-start flag, set after each SOH. A '1' at field start goes to TAG1. Other bytes stay in BODY.
  - TAG1: on '0' go to TAG10, otherwise back to BODY. The byte is appended either way.
  - TAG10: on '=' go to CKSUM and clear the digit counter, otherwise back to BODY. The byte is appended.
  - CKSUM: append each byte and count non-SOH bytes (saturating at 7). On SOH go to FLUSH; if the count != 3, pulse msg_err_o together with the final write.
  - FLUSH: one cycle; emit the partial word if any bytes are pending, then go to IDLE.
- "110=" and similar tags mid-field never trigger CKSUM. Only a field-start '1' does.
- If the closing SOH also fills a word, exactly one write carries end_message_o. FLUSH then emits nothing extra.
- Checksum value is not verified; only the digit count is checked.
- Overlong message: if the word count reaches MAX_MSG_WORDS without an end, the block forces that write to carry end_message_o and pulse msg_err_o. It then goes to IDLE and drops bytes until the next '8='.
- full_i=1 stalls byte acceptance. A write already registered still completes. No data is lost or duplicated.

Decomposition:
- Package fix_pkg holds:
  - the state enum: IDLE, HDR, BODY, TAG1, TAG10, CKSUM, FLUSH;
  - ASCII constants: ASC_SOH, ASC_8, ASC_EQ, ASC_1, ASC_0;
  - localparam BPW derived from DATA_WIDTH;
  - the checksum digit count, 3.
- Sub-module fix_byte_packer handles byte append, word-complete detection, zero-pad flush and the byte index counter. The FSM stays in fix_msg_framer.

Test Plan:
- Basic message, DATA_WIDTH=32: feed "8=A",01,"10=123",01, one byte per cycle -> three writes, data 0x01413D38 (start=1), 0x313D3031, 0x00013332 (end=1); msg_err_o=0.
- Leading garbage "XY8" then "8=A",01,"10=123",01 -> garbage and the first '8' are discarded; the same three words are written.
- Mid-field tag: "8=A",01,"5=110=",01,"10=123",01 -> no early end; end_message_o only on the final word.
- Bad checksum: "8=A",01,"10=12",01 -> last word written with end_message_o=1 and msg_err_o=1 in the same cycle.
- Backpressure: hold full_i=1 for 5 cycles mid-message -> byte_ready_o=0 throughout; written words identical to the unstalled run, with no gaps or duplicates.
- Reset after 2 of 3 words, then a fresh message -> no end_message_o for the aborted message; the new message's first write carries start_message_o.

Source files
------------

// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - shared state encoding and ASCII constants for the FIX message framer
package fix_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    BODY,
    TAG1,
    TAG10,
    CKSUM,
    FLUSH
  } fix_state_t;

  localparam logic [7:0] ASC_SOH = 8'h01;
  localparam logic [7:0] ASC_8   = 8'h38;
  localparam logic [7:0] ASC_EQ  = 8'h3D;
  localparam logic [7:0] ASC_1   = 8'h31;
  localparam logic [7:0] ASC_0   = 8'h30;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int BPW            = DEF_DATA_WIDTH / 8;
  localparam int CKSUM_DIGITS   = 3;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/fix_byte_packer.sv
// rtl/fix_byte_packer.sv - little-endian byte-to-word packer with zero-padded flush
module fix_byte_packer
  import fix_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  append,
  input  logic                  flush,
  input  logic [7:0]            din,
  output logic                  emit,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int NB = bytes_per_word(DATA_WIDTH);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_base;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_base;
  logic                  last_lane;

  // clear acts before append so a restart can drop the old bytes and load a new one together
  always_comb begin
    acc_base  = clear ? '0 : acc;
    idx_base  = clear ? '0 : idx;
    last_lane = (idx_base == IW'(NB - 1));
    word      = acc_base;
    if (append) begin
      word = acc_base | (DATA_WIDTH'(din) << (8 * idx_base));
    end
    emit = append ? last_lane : (flush && (idx_base != '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
    end else if (emit || (clear && !append)) begin
      acc <= '0;
      idx <= '0;
    end else if (append) begin
      acc <= word;
      idx <= idx_base + 1'b1;
    end
  end

endmodule

// File: rtl/fix_msg_framer.sv
// rtl/fix_msg_framer.sv - locates FIX message boundaries in a byte stream and writes packed words to cam_cntrl
module fix_msg_framer
  import fix_pkg::*;
#(
  parameter int         DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int         MAX_MSG_WORDS = 32,
  parameter logic [7:0] SOH           = ASC_SOH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  input  logic                  full_i,
  output logic                  wr_cs_o,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  start_message_o,
  output logic                  end_message_o,
  output logic                  msg_err_o
);

  localparam int             WCW       = $clog2(MAX_MSG_WORDS + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(MAX_MSG_WORDS - 1);

  fix_state_t            state;
  fix_state_t            state_nxt;
  fix_state_t            state_d;
  logic                  rdy_q;
  logic                  field_start;
  logic                  cksum_bad;
  logic [2:0]            digit_cnt;
  logic [WCW-1:0]        word_cnt;
  logic                  accept;
  logic                  is_soh;
  logic                  pk_clear;
  logic                  pk_append;
  logic                  pk_flush;
  logic                  pk_emit;
  logic [DATA_WIDTH-1:0] pk_word;
  logic                  natural_end;
  logic                  bad_now;
  logic                  overlong;

  // rdy_q keeps byte_ready_o low while reset is asserted
  assign byte_ready_o = rdy_q && !full_i && (state != FLUSH);
  assign accept       = byte_valid_i && byte_ready_o;
  assign is_soh       = (byte_i == SOH);

  always_comb begin
    pk_clear  = 1'b0;
    pk_append = 1'b0;
    pk_flush  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: if (accept && byte_i == ASC_8) begin
        pk_clear  = 1'b1;
        pk_append = 1'b1;
        state_nxt = HDR;
      end
      HDR: if (accept) begin
        if (byte_i == ASC_EQ) begin
          pk_append = 1'b1;
          state_nxt = BODY;
        end else if (byte_i == ASC_8) begin
          pk_clear  = 1'b1;
          pk_append = 1'b1;
        end else begin
          pk_clear  = 1'b1;
          state_nxt = IDLE;
        end
      end
      BODY: if (accept) begin
        pk_append = 1'b1;
        if (field_start && byte_i == ASC_1) state_nxt = TAG1;
      end
      TAG1: if (accept) begin
        pk_append = 1'b1;
        state_nxt = (byte_i == ASC_0) ? TAG10 : BODY;
      end
      TAG10: if (accept) begin
        pk_append = 1'b1;
        state_nxt = (byte_i == ASC_EQ) ? CKSUM : BODY;
      end
      CKSUM: if (accept) begin
        pk_append = 1'b1;
        if (is_soh) state_nxt = FLUSH;
      end
      FLUSH: begin
        pk_flush  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  fix_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk    (clk),
    .rst    (rst),
    .clear  (pk_clear),
    .append (pk_append),
    .flush  (pk_flush),
    .din    (byte_i),
    .emit   (pk_emit),
    .word   (pk_word)
  );

  // a write closes the message either at the checksum SOH/flush or when the word budget runs out
  assign natural_end = (state == FLUSH) || (state == CKSUM && accept && is_soh);
  assign bad_now     = (state == FLUSH) ? cksum_bad : (digit_cnt != 3'(CKSUM_DIGITS));
  assign overlong    = pk_emit && !natural_end && (word_cnt == LAST_WORD);
  assign state_d     = overlong ? IDLE : state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rdy_q           <= 1'b0;
      field_start     <= 1'b0;
      cksum_bad       <= 1'b0;
      digit_cnt       <= '0;
      word_cnt        <= '0;
      wr_cs_o         <= 1'b0;
      wr_en_o         <= 1'b0;
      data_o          <= '0;
      start_message_o <= 1'b0;
      end_message_o   <= 1'b0;
      msg_err_o       <= 1'b0;
    end else begin
      state <= state_d;
      rdy_q <= 1'b1;
      if (accept) field_start <= is_soh;
      if (accept && state == TAG10) begin
        digit_cnt <= '0;
      end else if (accept && state == CKSUM && !is_soh && digit_cnt != 3'd7) begin
        digit_cnt <= digit_cnt + 1'b1;
      end
      if (accept && state == CKSUM && is_soh) cksum_bad <= (digit_cnt != 3'(CKSUM_DIGITS));
      if (pk_emit) begin
        word_cnt <= word_cnt + 1'b1;
      end else if (state == IDLE) begin
        word_cnt <= '0;
      end
      wr_cs_o         <= pk_emit;
      wr_en_o         <= pk_emit;
      if (pk_emit) data_o <= pk_word;
      start_message_o <= pk_emit && (word_cnt == '0);
      end_message_o   <= pk_emit && (natural_end || overlong);
      msg_err_o       <= overlong || (pk_emit && natural_end && bad_now);
    end
  end

endmodule

// File: tb/tb_fix_msg_framer.sv
// tb/tb_fix_msg_framer.sv - self-checking bench for fix_msg_framer
module tb_fix_msg_framer;

  localparam int         DW   = 32;
  localparam int         NB   = DW / 8;
  localparam int         MAXW = 8;
  localparam logic [7:0] SOH  = 8'h01;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_i = 8'h00;
  logic          byte_valid_i = 1'b0;
  logic          full_i = 1'b0;
  logic          byte_ready_o;
  logic          wr_cs_o;
  logic          wr_en_o;
  logic [DW-1:0] data_o;
  logic          start_message_o;
  logic          end_message_o;
  logic          msg_err_o;

  int tests = 0;
  int fails = 0;

  logic [34:0] cap_q[$];
  logic [34:0] exp_q[$];
  logic [7:0]  stim_q[$];

  typedef struct {
    string             name;
    string             s;
    int                n;
    logic [11:0][34:0] w;
  } vec_t;

  vec_t vecs[8];
  int   nv = 0;

  always #5 clk = ~clk;

  fix_msg_framer #(.DATA_WIDTH(DW), .MAX_MSG_WORDS(MAXW), .SOH(SOH)) dut (
    .clk             (clk),
    .rst             (rst),
    .byte_i          (byte_i),
    .byte_valid_i    (byte_valid_i),
    .byte_ready_o    (byte_ready_o),
    .full_i          (full_i),
    .wr_cs_o         (wr_cs_o),
    .wr_en_o         (wr_en_o),
    .data_o          (data_o),
    .start_message_o (start_message_o),
    .end_message_o   (end_message_o),
    .msg_err_o       (msg_err_o)
  );

  always @(negedge clk) begin
    if (wr_en_o || wr_cs_o) begin
      cap_q.push_back({msg_err_o, end_message_o, start_message_o, data_o});
      tests++;
      if (wr_cs_o !== wr_en_o) begin
        fails++;
        $display("FAIL cs_en_pair: wr_cs=%b wr_en=%b required equal", wr_cs_o, wr_en_o);
      end
    end
  end

  function automatic logic [34:0] mkw(bit e, bit en, bit st, logic [31:0] d);
    return {e, en, st, d};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic compare_q(string name);
    int m;
    check({name, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
    m = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      check($sformatf("%s_w%0d", name, k), 64'(cap_q[k]), 64'(exp_q[k]));
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    byte_valid_i = 1'b0;
    full_i       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cap_q.delete();
  endtask

  task automatic load_str(string str);
    stim_q.delete();
    for (int k = 0; k < str.len(); k++) stim_q.push_back(str[k]);
  endtask

  task automatic send(input logic [7:0] s[$], input bit rnd);
    for (int k = 0; k < s.size(); k++) begin
      int waited = 0;
      bit done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (rnd) begin
          full_i       = ($urandom_range(0, 3) == 0);
          byte_valid_i = ($urandom_range(0, 4) != 0);
        end else begin
          full_i       = 1'b0;
          byte_valid_i = 1'b1;
        end
        byte_i = s[k];
        #1;
        done = byte_valid_i && byte_ready_o;
        waited++;
        if (!done && waited > 200) begin
          tests++;
          fails++;
          $display("FAIL send_timeout: byte %0d not accepted after %0d cycles, required acceptance", k, waited);
          byte_valid_i = 1'b0;
          full_i       = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
    full_i       = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  // Reference: find "8=", scan fields for a field-start "10=", close at the following SOH,
  // cap the message at MAXW words, then pack little-endian.
  function automatic void model(input logic [7:0] s[$]);
    int n, i, k, digits, len, nw, cap;
    bit ended, bad, in_ck, forced, last;
    logic [31:0] d;
    n   = s.size();
    i   = 0;
    cap = MAXW * NB;
    exp_q.delete();
    while (i < n) begin
      if (s[i] == 8'h38 && i + 1 < n && s[i+1] == 8'h3D) begin
        k = i + 2; ended = 0; bad = 0; in_ck = 0; digits = 0;
        while (k < n && !ended) begin
          if (in_ck) begin
            if (s[k] == SOH) begin
              ended = 1;
              bad   = (digits != 3);
            end else begin
              digits++;
              k++;
            end
          end else if (s[k-1] == SOH && k + 2 < n && s[k] == 8'h31 && s[k+1] == 8'h30 && s[k+2] == 8'h3D) begin
            in_ck = 1;
            k += 3;
          end else begin
            k++;
          end
        end
        len    = ended ? (k - i + 1) : (n - i);
        forced = ended ? (len > cap) : (len >= cap);
        if (forced) len = cap;
        nw = (ended || forced) ? (len + NB - 1) / NB : len / NB;
        for (int w = 0; w < nw; w++) begin
          d = '0;
          for (int b = 0; b < NB; b++) if (w * NB + b < len) d[8*b +: 8] = s[i + w*NB + b];
          last = (w == nw - 1) && (ended || forced);
          exp_q.push_back(mkw(last && (forced || bad), last, (w == 0), d));
        end
        i += len;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic push_str(string str);
    for (int k = 0; k < str.len(); k++) stim_q.push_back(str[k]);
  endtask

  task automatic gen_random();
    logic [7:0] alpha[8];
    logic [7:0] vals[7];
    string      tags[6];
    int         nf, nd;
    alpha = '{8'h38, 8'h3D, 8'h31, 8'h30, SOH, 8'h41, 8'h32, 8'h35};
    vals  = '{8'h41, 8'h42, 8'h31, 8'h30, 8'h3D, 8'h38, 8'h32};
    tags  = '{"35", "5", "110", "1", "10", "8"};
    stim_q.delete();
    repeat ($urandom_range(2, 5)) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) stim_q.push_back(alpha[$urandom_range(0, 7)]);
      end else begin
        push_str("8=");
        nf = ($urandom_range(0, 5) == 0) ? 8 : $urandom_range(0, 3);
        repeat (nf) begin
          push_str(tags[$urandom_range(0, 5)]);
          stim_q.push_back(8'h3D);
          repeat ($urandom_range(1, 4)) stim_q.push_back(vals[$urandom_range(0, 6)]);
          stim_q.push_back(SOH);
        end
        if ($urandom_range(0, 4) != 0) begin
          push_str("10=");
          nd = ($urandom_range(0, 1) == 0) ? 3 : $urandom_range(0, 8);
          repeat (nd) stim_q.push_back(8'h30 + 8'($urandom_range(0, 9)));
          stim_q.push_back(SOH);
        end
      end
    end
  endtask

  task automatic add_vec(string name, string s);
    vecs[nv].name = name;
    vecs[nv].s    = s;
    vecs[nv].n    = 0;
    vecs[nv].w    = '0;
    nv++;
  endtask

  task automatic add_w(logic [34:0] w);
    vecs[nv-1].w[vecs[nv-1].n] = w;
    vecs[nv-1].n++;
  endtask

  task automatic expect_basic();
    exp_q.delete();
    exp_q.push_back(mkw(0, 0, 1, 32'h01413D38));
    exp_q.push_back(mkw(0, 0, 0, 32'h313D3031));
    exp_q.push_back(mkw(0, 1, 0, 32'h00013332));
  endtask

  initial begin
    string a34;
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    a34 = "";
    for (int k = 0; k < 34; k++) a34 = {a34, "A"};

    add_vec("basic", "8=A\00110=123\001");
    add_w(mkw(0, 0, 1, 32'h01413D38)); add_w(mkw(0, 0, 0, 32'h313D3031)); add_w(mkw(0, 1, 0, 32'h00013332));
    add_vec("garbage", "XY88=A\00110=123\001");
    add_w(mkw(0, 0, 1, 32'h01413D38)); add_w(mkw(0, 0, 0, 32'h313D3031)); add_w(mkw(0, 1, 0, 32'h00013332));
    add_vec("midtag", "8=A\0015=110=\00110=123\001");
    add_w(mkw(0, 0, 1, 32'h01413D38)); add_w(mkw(0, 0, 0, 32'h31313D35)); add_w(mkw(0, 0, 0, 32'h31013D30));
    add_w(mkw(0, 0, 0, 32'h32313D30)); add_w(mkw(0, 1, 0, 32'h00000133));
    add_vec("badck", "8=A\00110=12\001");
    add_w(mkw(0, 0, 1, 32'h01413D38)); add_w(mkw(0, 0, 0, 32'h313D3031)); add_w(mkw(1, 1, 0, 32'h00000132));
    add_vec("longck", "8=A\00110=12345\001");
    add_w(mkw(0, 0, 1, 32'h01413D38)); add_w(mkw(0, 0, 0, 32'h313D3031)); add_w(mkw(0, 0, 0, 32'h35343332));
    add_w(mkw(1, 1, 0, 32'h00000001));
    add_vec("soh_fill", "8=AB\00110=123\001");
    add_w(mkw(0, 0, 1, 32'h42413D38)); add_w(mkw(0, 0, 0, 32'h3D303101)); add_w(mkw(0, 1, 0, 32'h01333231));
    add_vec("overlong", {"8=", a34, "8=A\00110=123\001"});
    add_w(mkw(0, 0, 1, 32'h41413D38));
    for (int k = 0; k < 6; k++) add_w(mkw(0, 0, 0, 32'h41414141));
    add_w(mkw(1, 1, 0, 32'h41414141));
    add_w(mkw(0, 0, 1, 32'h01413D38)); add_w(mkw(0, 0, 0, 32'h313D3031)); add_w(mkw(0, 1, 0, 32'h00013332));

    // reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({byte_ready_o, wr_cs_o, wr_en_o, data_o, start_message_o, end_message_o, msg_err_o}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(byte_ready_o), 64'd1);

    for (int v = 0; v < nv; v++) begin
      do_reset();
      load_str(vecs[v].s);
      send(stim_q, 1'b0);
      drain();
      exp_q.delete();
      for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].w[k]);
      compare_q(vecs[v].name);
    end

    // backpressure: five stalled cycles after the fifth byte
    do_reset();
    load_str("8=A\00110=123\001");
    q1 = stim_q[0:4];
    q2 = stim_q[5:$];
    send(q1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      full_i       = 1'b1;
      byte_valid_i = 1'b1;
      byte_i       = q2[0];
      #1;
      check($sformatf("bp_ready_c%0d", c), 64'(byte_ready_o), 64'd0);
    end
    send(q2, 1'b0);
    drain();
    expect_basic();
    compare_q("backpressure");

    // reset after two of three words
    do_reset();
    load_str("8=A\00110=1");
    send(stim_q, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_words", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() >= 2) check("abort_no_end", 64'({cap_q[0][33], cap_q[1][33]}), 64'd0);
    rst = 1'b1;
    #1;
    check("midreset_outputs", 64'({byte_ready_o, wr_cs_o, wr_en_o, data_o, start_message_o, end_message_o, msg_err_o}), 64'd0);
    do_reset();
    load_str("8=A\00110=123\001");
    send(stim_q, 1'b0);
    drain();
    expect_basic();
    compare_q("after_abort");

    // randomized streams with random valid gaps and backpressure
    for (int it = 0; it < 30; it++) begin
      do_reset();
      gen_random();
      model(stim_q);
      send(stim_q, 1'b1);
      drain();
      compare_q($sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
